// File: rtl/rf_sched_pkg.sv
// Shared types and helpers for the register-file write-port scheduler.
package rf_sched_pkg;

    localparam int RF_AW = 5;
    localparam int RF_DW = 32;

    typedef logic [RF_AW-1:0] rf_addr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    // Counter k preload value; the product wraps modulo 2^32 by design.
    function automatic logic [RF_DW-1:0] init_value(
        input logic [3:0]       k,
        input logic [RF_DW-1:0] base,
        input logic [RF_DW-1:0] step
    );
        return base + (RF_DW'(k) * step);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for the asynchronous board switches.
module sync_2ff #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_r;
    logic [W-1:0] sync_r;

    // Metastability-settling flop pair.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_r <= '0;
            sync_r <= '0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/rf_wport_sched.sv
// Single write-port scheduler: pipeline > counter-init sequencer > switch sampler.
// Optional switch sampler enabled by defining RF_SW_SAMPLE_EN.
module rf_wport_sched
    import rf_sched_pkg::*;
#(
    parameter int unsigned      NUM_CNT   = 4,
    parameter rf_addr_t         CNT_BASE  = 5'd8,
    parameter logic [RF_DW-1:0] INIT_VAL  = 32'd0,
    parameter logic [RF_DW-1:0] INIT_STEP = 32'd16,
    parameter rf_addr_t         SW_REG    = 5'd7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWriteW,
    input  rf_addr_t         WA3W,
    input  logic [RF_DW-1:0] ResultW,
    input  logic             init_start,
    input  logic [2:0]       Switches,
    output logic             rf_we,
    output rf_addr_t         rf_wa,
    output logic [RF_DW-1:0] rf_wd,
    output logic             init_busy,
    output logic             init_done
);

    localparam int IDX_W = 4;
    localparam logic [NUM_CNT-1:0] ONE_BIT = NUM_CNT'(1'b1);

    sched_state_t       state_r, state_nxt_s;
    logic [NUM_CNT-1:0] pend_mask_r, pend_mask_nxt_s;
    logic [IDX_W-1:0]   idx_r, idx_nxt_s;
    logic               cnt_hit_s;
    rf_addr_t           cnt_off_s;
    logic               pend_cur_s;
    logic               seq_we_s;
    logic               sw_we_s;
    logic [2:0]         sw_val_s;

    // Detect a pipeline write landing on one of the counter registers.
    always_comb begin
        cnt_off_s = WA3W - CNT_BASE;
        if (RegWriteW && ({1'b0, WA3W} >= {1'b0, CNT_BASE}) &&
            ({1'b0, WA3W} < ({1'b0, CNT_BASE} + 6'(NUM_CNT)))) begin
            cnt_hit_s = 1'b1;
        end else begin
            cnt_hit_s = 1'b0;
        end
    end

    assign pend_cur_s = |(pend_mask_r & (ONE_BIT << idx_r));

    // Sequencer next-state: the pipeline always owns the port, so LOAD only advances on free cycles.
    always_comb begin
        state_nxt_s     = state_r;
        idx_nxt_s       = idx_r;
        seq_we_s        = 1'b0;
        if (cnt_hit_s) begin
            pend_mask_nxt_s = pend_mask_r & ~(ONE_BIT << cnt_off_s);
        end else begin
            pend_mask_nxt_s = pend_mask_r;
        end
        case (state_r)
            IDLE: begin
                if (init_start) begin
                    state_nxt_s     = LOAD;
                    pend_mask_nxt_s = {NUM_CNT{1'b1}};
                    idx_nxt_s       = {IDX_W{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                if (RegWriteW) begin
                    state_nxt_s = LOAD;
                end else begin
                    if (pend_cur_s) begin
                        seq_we_s        = 1'b1;
                        pend_mask_nxt_s = pend_mask_r & ~(ONE_BIT << idx_r);
                    end else begin
                        seq_we_s = 1'b0;
                    end
                    idx_nxt_s = idx_r + 4'd1;
                    if (idx_nxt_s == IDX_W'(NUM_CNT)) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = LOAD;
                    end
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Sequencer state registers; reset aborts any init in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            pend_mask_r <= '0;
            idx_r       <= '0;
        end else begin
            state_r     <= state_nxt_s;
            pend_mask_r <= pend_mask_nxt_s;
            idx_r       <= idx_nxt_s;
        end
    end

`ifdef RF_SW_SAMPLE_EN
    logic [2:0] sw_sync_s;
    logic [2:0] sw_last_r;
    logic       sw_pend_r;

    sync_2ff #(.W(3)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (Switches),
        .q     (sw_sync_s)
    );

    assign sw_we_s  = sw_pend_r && !RegWriteW && (state_r != LOAD);
    assign sw_val_s = sw_sync_s;

    // Switch change tracking; the write always carries the newest synchronised value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_last_r <= '0;
            sw_pend_r <= 1'b0;
        end else if (sw_we_s) begin
            sw_last_r <= sw_sync_s;
            sw_pend_r <= 1'b0;
        end else if (sw_sync_s != sw_last_r) begin
            sw_pend_r <= 1'b1;
        end else begin
            sw_pend_r <= sw_pend_r;
        end
    end
`else
    logic unused_switches_s;
    assign unused_switches_s = ^Switches;
    assign sw_we_s  = 1'b0;
    assign sw_val_s = 3'b000;
`endif

    // Write-port mux; everything is forced quiet while reset is held.
    always_comb begin
        rf_we = 1'b0;
        rf_wa = '0;
        rf_wd = '0;
        if (reset) begin
            rf_we = 1'b0;
        end else if (RegWriteW) begin
            rf_we = 1'b1;
            rf_wa = WA3W;
            rf_wd = ResultW;
        end else if (seq_we_s) begin
            rf_we = 1'b1;
            rf_wa = CNT_BASE + rf_addr_t'(idx_r);
            rf_wd = init_value(idx_r, INIT_VAL, INIT_STEP);
        end else if (sw_we_s) begin
            rf_we = 1'b1;
            rf_wa = SW_REG;
            rf_wd = {29'd0, sw_val_s};
        end else begin
            rf_we = 1'b0;
        end
    end

    assign init_busy = (state_r == LOAD);
    assign init_done = (state_r == DONE);

endmodule
